turfio_cin_train_ctrl: RTL and testbench

Automatic alignment-training controller for one TURFIO CIN parallel-sync lane. It sits directly upstream of the CIN parallel-sync stage: it drives that stage's bitslip reset, bitslip, capture/captured handshake and enable, and reads back its captured 32-bit word and bit-error flag. It searches the four bitslip positions for the 32-bit training pattern and reports the bitslip count and the nibble rotation, which software converts into the phase offset. When the lane is aligned it releases `enable_o`.

---
 rtl/turfio_cin_pkg.sv | 29 ++
 rtl/cin_pattern_match.sv | 28 ++
 rtl/turfio_cin_train_ctrl.sv | 162 ++++++++++++++++
 tb/tb_turfio_cin_train_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turfio_cin_pkg.sv
// Shared definitions for the TURFIO CIN alignment-training logic.
//   cin_train_state_t     : training FSM state encoding
//   TrainSequenceDefault  : default 32-bit training word
//   nib_rotr(word, k)     : rotate word right by 4*k bits
package turfio_cin_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StSlipRst,
        StSettle,
        StErrChk,
        StCapt,
        StCwait,
        StCompare,
        StSlip,
        StLocked,
        StFail
    } cin_train_state_t;

    localparam logic [31:0] TrainSequenceDefault = 32'hA55A6996;

    function automatic logic [31:0] nib_rotr(input logic [31:0] word, input logic [2:0] k);
        logic [63:0] dbl;
        // Doubling the word turns the rotate into a plain shift.
        dbl = {word, word} >> {k, 2'b00};
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/cin_pattern_match.sv
// Combinational rotation matcher: compares word_i against the pattern rotated right by
// 4k bits for k = 0..7 and reports the lowest matching k.
//   word_i : captured 32-bit word
//   hit_o  : some rotation matched
//   k_o    : lowest matching nibble rotation (0 when no hit)
module cin_pattern_match
    import turfio_cin_pkg::*;
#(
    parameter logic [31:0] PATTERN = TrainSequenceDefault
) (
    input  logic [31:0] word_i,
    output logic        hit_o,
    output logic [2:0]  k_o
);

    always_comb begin
        hit_o = 1'b0;
        k_o   = 3'd0;
        // Walk from k=7 down so the lowest matching k is the one left standing.
        for (int i = 7; i >= 0; i--) begin
            if (word_i == nib_rotr(PATTERN, 3'(i))) begin
                hit_o = 1'b1;
                k_o   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/turfio_cin_train_ctrl.sv
// Alignment-training controller for one TURFIO CIN parallel-sync lane. Searches the four
// bitslip positions for the training word and reports slip count and nibble rotation.
//   ifclk_i, rstn_i      : clock, asynchronous active-low reset
//   start_i              : start training (accepted in idle/locked/fail)
//   cin_parallel_i       : captured word from the sync stage
//   cin_biterr_i         : bit-error flag from the sync stage
//   rst_bitslip_o, bitslip_o, capture_o, captured_o : single-cycle control pulses
//   enable_o             : lane enable, high only while locked
//   busy_o, locked_o, fail_o, err_o : status (err_o: 1 = bit error, 0 = no match)
//   slip_o, rot_o        : bitslip count and nibble rotation result
module turfio_cin_train_ctrl
    import turfio_cin_pkg::*;
#(
    parameter logic [31:0] TRAIN_SEQUENCE = TrainSequenceDefault,
    parameter int unsigned SETTLE_CYCLES  = 32,
    parameter int unsigned ERR_WINDOW     = 256
) (
    input  logic        ifclk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic [31:0] cin_parallel_i,
    input  logic        cin_biterr_i,
    output logic        rst_bitslip_o,
    output logic        bitslip_o,
    output logic        capture_o,
    output logic        captured_o,
    output logic        enable_o,
    output logic        busy_o,
    output logic        locked_o,
    output logic        fail_o,
    output logic        err_o,
    output logic [1:0]  slip_o,
    output logic [2:0]  rot_o
);

    localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] WinLoad    = 16'(ERR_WINDOW - 1);

    cin_train_state_t state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [1:0]       slip_q, slip_d;
    logic [2:0]       rot_q, rot_d;
    logic             err_q, err_d;

    logic             hit;
    logic [2:0]       hit_k;

    cin_pattern_match #(
        .PATTERN (TRAIN_SEQUENCE)
    ) u_match (
        .word_i (cin_parallel_i),
        .hit_o  (hit),
        .k_o    (hit_k)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slip_d  = slip_q;
        rot_d   = rot_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle, StLocked, StFail: begin
                if (start_i) begin
                    state_d = StSlipRst;
                    slip_d  = 2'd0;
                    rot_d   = 3'd0;
                    err_d   = 1'b0;
                end
            end
            StSlipRst: begin
                state_d = StSettle;
                cnt_d   = SettleLoad;
            end
            StSettle: begin
                if (cnt_q == 16'd0) begin
                    state_d = StErrChk;
                    cnt_d   = WinLoad;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StErrChk: begin
                if (cin_biterr_i) begin
                    state_d = StFail;
                    err_d   = 1'b1;
                end else if (cnt_q == 16'd0) begin
                    state_d = StCapt;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StCapt: begin
                state_d = StCwait;
                cnt_d   = 16'd1;
            end
            StCwait: begin
                if (cnt_q == 16'd0) begin
                    state_d = StCompare;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StCompare: begin
                if (hit) begin
                    state_d = StLocked;
                    rot_d   = hit_k;
                end else if (slip_q == 2'd3) begin
                    state_d = StFail;
                    err_d   = 1'b0;
                end else begin
                    state_d = StSlip;
                end
            end
            StSlip: begin
                state_d = StSettle;
                cnt_d   = SettleLoad;
                slip_d  = slip_q + 2'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its state.
    always_ff @(posedge ifclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= StIdle;
            cnt_q         <= 16'd0;
            slip_q        <= 2'd0;
            rot_q         <= 3'd0;
            err_q         <= 1'b0;
            rst_bitslip_o <= 1'b0;
            bitslip_o     <= 1'b0;
            capture_o     <= 1'b0;
            captured_o    <= 1'b0;
            enable_o      <= 1'b0;
            busy_o        <= 1'b0;
            locked_o      <= 1'b0;
            fail_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            slip_q        <= slip_d;
            rot_q         <= rot_d;
            err_q         <= err_d;
            rst_bitslip_o <= (state_d == StSlipRst);
            bitslip_o     <= (state_d == StSlip);
            capture_o     <= (state_d == StCapt);
            captured_o    <= (state_d == StCompare);
            enable_o      <= (state_d == StLocked);
            locked_o      <= (state_d == StLocked);
            fail_o        <= (state_d == StFail);
            busy_o        <= !((state_d == StIdle) || (state_d == StLocked)
                               || (state_d == StFail));
        end
    end

    assign err_o  = err_q;
    assign slip_o = slip_q;
    assign rot_o  = rot_q;

endmodule

// File: tb/tb_turfio_cin_train_ctrl.sv
module tb_turfio_cin_train_ctrl;

    localparam int S = 10;
    localparam int W = 4;

    logic        ifclk_i = 1'b0;
    logic        rstn_i  = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] cin_parallel_i;
    logic        cin_biterr_i = 1'b0;
    logic        rst_bitslip_o, bitslip_o, capture_o, captured_o;
    logic        enable_o, busy_o, locked_o, fail_o, err_o;
    logic [1:0]  slip_o;
    logic [2:0]  rot_o;

    int checks = 0;
    int errors = 0;

    // Sync-stage model state, driven only by the monitor.
    int mode = 0;
    int model_slip = 0;
    int n_rst = 0, n_slip = 0, n_cap = 0, n_capd = 0, n_viol = 0;
    int cap_age = 0;

    turfio_cin_train_ctrl #(
        .TRAIN_SEQUENCE (32'hA55A6996),
        .SETTLE_CYCLES  (S),
        .ERR_WINDOW     (W)
    ) dut (
        .ifclk_i        (ifclk_i),
        .rstn_i         (rstn_i),
        .start_i        (start_i),
        .cin_parallel_i (cin_parallel_i),
        .cin_biterr_i   (cin_biterr_i),
        .rst_bitslip_o  (rst_bitslip_o),
        .bitslip_o      (bitslip_o),
        .capture_o      (capture_o),
        .captured_o     (captured_o),
        .enable_o       (enable_o),
        .busy_o         (busy_o),
        .locked_o       (locked_o),
        .fail_o         (fail_o),
        .err_o          (err_o),
        .slip_o         (slip_o),
        .rot_o          (rot_o)
    );

    always #5 ifclk_i = ~ifclk_i;

    always_comb begin
        case (mode)
            0:       cin_parallel_i = 32'hA55A6996;
            1:       cin_parallel_i = (model_slip == 2) ? 32'h6A55A699 : 32'h0F0F0F0F;
            default: cin_parallel_i = 32'h12345678;
        endcase
    end

    always @(negedge ifclk_i) begin
        if (!rstn_i) begin
            cap_age = 0;
        end else begin
            if (rst_bitslip_o) begin n_rst++; model_slip = 0; end
            if (bitslip_o) begin n_slip++; model_slip++; end
            if (capture_o) n_cap++;
            if (captured_o) n_capd++;
            if (capture_o && captured_o) n_viol++;
            if (captured_o && cap_age != 3) n_viol++;
            if (capture_o) cap_age = 1;
            else if (captured_o) cap_age = 0;
            else if (cap_age != 0) cap_age++;
            if (cap_age > 3) begin n_viol++; cap_age = 0; end
        end
    end

    task automatic step();
        @(posedge ifclk_i);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        #12;
        checks++;
        if ({rst_bitslip_o, bitslip_o, capture_o, captured_o, enable_o, busy_o, locked_o,
             fail_o, err_o, slip_o, rot_o} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {rst_bitslip_o, bitslip_o,
                     capture_o, captured_o, enable_o, busy_o, locked_o, fail_o, err_o,
                     slip_o, rot_o});
        end
        step();
        rstn_i = 1'b1;
        repeat (3) step();
        checks++;
        if ({busy_o, locked_o, fail_o, enable_o} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 0000",
                     {busy_o, locked_o, fail_o, enable_o});
        end
    endtask

    task automatic test_lock_slip0();
        int n, r0, s0, v0;
        mode = 0;
        r0 = n_rst; s0 = n_slip; v0 = n_viol;
        pulse_start();
        n = 1;
        while (!capture_o && n < 200) begin step(); n++; end
        checks++;
        if (n != S + W + 2) begin
            errors++;
            $display("FAIL first_capture_latency: got %0d required %0d", n, S + W + 2);
        end
        while (!locked_o && n < 400) begin step(); n++; end
        checks++;
        if (n != S + W + 6) begin
            errors++;
            $display("FAIL lock_latency: got %0d required %0d", n, S + W + 6);
        end
        checks++;
        if ({locked_o, enable_o, busy_o, fail_o, slip_o, rot_o} !== {4'b1100, 2'd0, 3'd0}) begin
            errors++;
            $display("FAIL lock0_status: got l%b e%b b%b f%b s%0d r%0d required l1 e1 b0 f0 s0 r0",
                     locked_o, enable_o, busy_o, fail_o, slip_o, rot_o);
        end
        checks++;
        if (n_rst - r0 != 1 || n_slip - s0 != 0) begin
            errors++;
            $display("FAIL lock0_pulses: got rst %0d slip %0d required rst 1 slip 0",
                     n_rst - r0, n_slip - s0);
        end
        checks++;
        if (n_viol != v0) begin
            errors++;
            $display("FAIL lock0_handshake: got %0d violations required 0", n_viol - v0);
        end
    endtask

    task automatic test_lock_slip2();
        int n, s0, c0;
        mode = 1;
        s0 = n_slip; c0 = n_cap;
        pulse_start();
        n = 1;
        while (busy_o && n < 2000) begin step(); n++; end
        checks++;
        if ({locked_o, enable_o, fail_o, slip_o, rot_o} !== {3'b110, 2'd2, 3'd1}) begin
            errors++;
            $display("FAIL lock2_status: got l%b e%b f%b s%0d r%0d required l1 e1 f0 s2 r1",
                     locked_o, enable_o, fail_o, slip_o, rot_o);
        end
        checks++;
        if (n_slip - s0 != 2 || n_cap - c0 != 3) begin
            errors++;
            $display("FAIL lock2_pulses: got slips %0d caps %0d required slips 2 caps 3",
                     n_slip - s0, n_cap - c0);
        end
    endtask

    task automatic test_fail_nomatch();
        int n, s0, c0, v0;
        mode = 2;
        s0 = n_slip; c0 = n_cap; v0 = n_viol;
        pulse_start();
        n = 1;
        while (busy_o && n < 2000) begin step(); n++; end
        checks++;
        if ({fail_o, err_o, locked_o, enable_o, slip_o} !== {4'b1000, 2'd3}) begin
            errors++;
            $display("FAIL nomatch_status: got f%b err%b l%b e%b s%0d required f1 err0 l0 e0 s3",
                     fail_o, err_o, locked_o, enable_o, slip_o);
        end
        checks++;
        if (n_slip - s0 != 3 || n_cap - c0 != 4 || n_viol != v0) begin
            errors++;
            $display("FAIL nomatch_pulses: got slips %0d caps %0d viol %0d required 3 4 0",
                     n_slip - s0, n_cap - c0, n_viol - v0);
        end
    endtask

    task automatic test_biterr();
        int n, c0;
        mode = 0;
        c0 = n_cap;
        pulse_start();
        n = 1;
        while (n < S + 2) begin step(); n++; end
        cin_biterr_i = 1'b1;
        step();
        cin_biterr_i = 1'b0;
        n++;
        while (busy_o && n < 2000) begin step(); n++; end
        checks++;
        if ({fail_o, err_o, locked_o, enable_o, slip_o} !== {4'b1100, 2'd0}) begin
            errors++;
            $display("FAIL biterr_status: got f%b err%b l%b e%b s%0d required f1 err1 l0 e0 s0",
                     fail_o, err_o, locked_o, enable_o, slip_o);
        end
        checks++;
        if (n_cap != c0) begin
            errors++;
            $display("FAIL biterr_no_capture: got %0d captures required 0", n_cap - c0);
        end
    endtask

    task automatic test_reset_cwait();
        int n, d0, c0;
        mode = 0;
        pulse_start();
        n = 1;
        while (!capture_o && n < 200) begin step(); n++; end
        d0 = n_capd;
        step();
        rstn_i = 1'b0;
        #1;
        checks++;
        if ({rst_bitslip_o, bitslip_o, capture_o, captured_o, enable_o, busy_o, locked_o,
             fail_o, err_o, slip_o, rot_o} !== 14'd0) begin
            errors++;
            $display("FAIL cwait_reset_outputs: got %b required 0", {rst_bitslip_o, bitslip_o,
                     capture_o, captured_o, enable_o, busy_o, locked_o, fail_o, err_o,
                     slip_o, rot_o});
        end
        repeat (2) step();
        rstn_i = 1'b1;
        repeat (5) step();
        checks++;
        if (n_capd != d0) begin
            errors++;
            $display("FAIL cwait_no_captured: got %0d captured required 0", n_capd - d0);
        end
        c0 = n_cap; d0 = n_capd;
        pulse_start();
        n = 1;
        while (busy_o && n < 2000) begin step(); n++; end
        checks++;
        if (locked_o !== 1'b1 || n_cap - c0 != 1 || n_capd - d0 != 1) begin
            errors++;
            $display("FAIL retrain_after_reset: got l%b caps %0d capd %0d required l1 1 1",
                     locked_o, n_cap - c0, n_capd - d0);
        end
    endtask

    task automatic test_start_busy();
        int n, ncap, r0;
        mode = 0;
        r0 = n_rst;
        ncap = 0;
        pulse_start();
        n = 1;
        while (!locked_o && n < 400) begin
            step();
            n++;
            start_i = (n == 5);
            cin_biterr_i = (n == 6);  // during SETTLE, must be ignored
            if (capture_o && ncap == 0) ncap = n;
        end
        start_i = 1'b0;
        cin_biterr_i = 1'b0;
        checks++;
        if (ncap != S + W + 2 || n != S + W + 6) begin
            errors++;
            $display("FAIL busy_start_timing: got cap %0d lock %0d required cap %0d lock %0d",
                     ncap, n, S + W + 2, S + W + 6);
        end
        checks++;
        if (n_rst - r0 != 1 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored: got rst %0d l%b required rst 1 l1",
                     n_rst - r0, locked_o);
        end
    endtask

    initial begin
        test_reset();
        test_lock_slip0();
        test_lock_slip2();
        test_fail_nomatch();
        test_biterr();
        test_reset_cwait();
        test_start_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
